cache_l1_wb: RTL
================

// Module: cache_l1_wb
// PURPOSE
//  Parametrised direct-mapped, write-back, write-allocate L1 cache controller, one word per line.
//  Sits between the board/CPU request port and the next memory level (L2 or main RAM).
//  Reports hit/miss per access and, optionally, hit/miss statistics.
// PARAMETERS
//  ADDR_W   16  address width in words; tag = addr[ADDR_W-1:INDEX_W], index = addr[INDEX_W-1:0]
//  DATA_W   16  data word width
//  INDEX_W  3   log2(lines); LINES = 2**INDEX_W; 1 <= INDEX_W < ADDR_W
// PORTS
//  clock       in   1        single clock, all logic on rising edge
//  reset       in   1        synchronous, active-high
//  req_valid   in   1        CPU request present
//  req_write   in   1        1 = write, 0 = read
//  req_addr    in   ADDR_W   word address
//  req_wdata   in   DATA_W   write data
//  req_ready   out  1        controller accepts request this cycle
//  resp_valid  out  1        one-cycle pulse: access complete
//  resp_rdata  out  DATA_W   read data (valid with resp_valid on reads; 0 on writes)
//  resp_hit    out  1        1 = hit on first lookup, valid with resp_valid
//  mem_req     out  1        next-level request, held until mem_ack
//  mem_write   out  1        1 = writeback, 0 = fill read
//  mem_addr    out  ADDR_W   next-level word address
//  mem_wdata   out  DATA_W   writeback data
//  mem_ack     in   1        next level completes transaction this cycle
//  mem_rdata   in   DATA_W   fill data, valid when mem_ack=1 and mem_write=0
//  hit_count   out  16       hits since reset (STATS_EN only)
//  miss_count  out  16       misses since reset (STATS_EN only)
// BEHAVIOUR
//  Reset: state IDLE; all valid/dirty bits 0; req_ready=1; resp_valid=0; resp_rdata=0; resp_hit=0;
//   mem_req=0; mem_write=0; mem_addr=0; mem_wdata=0; counters 0. Tag/data arrays not reset.
//  Accept: req_valid&&req_ready at edge -> addr/wdata/write registered; req_ready=1 only in IDLE.
//  FSM: IDLE -> COMPARE on accept.
//   COMPARE: hit = valid[idx] && tag[idx]==req tag.
//    hit read -> resp_valid=1, resp_rdata=data[idx], resp_hit=1 -> IDLE.
//    hit write -> data[idx]=wdata, dirty[idx]=1, resp_valid=1, resp_hit=1 -> IDLE.
//    miss, valid&&dirty -> WRITEBACK; miss otherwise -> FILL.
//   WRITEBACK: mem_req=1, mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx]; on mem_ack -> FILL.
//   FILL: mem_req=1, mem_write=0, mem_addr=req addr; on mem_ack: tag/valid set, data=mem_rdata -> RESPOND.
//   RESPOND: read -> resp_rdata=line data, dirty=0; write -> data=wdata, dirty=1; resp_valid=1,
//    resp_hit=0 -> IDLE.
//  Latency: hit response 1 cycle after accept; miss response 1 cycle after final mem_ack.
//  Handshake: mem_req/mem_addr/mem_wdata registered, stable until mem_ack sampled 1; mem_req low the
//   cycle after ack; mem_ack while mem_req=0 ignored. Back-to-back WRITEBACK->FILL keeps mem_req high.
//  resp_valid is a single-cycle pulse; resp_rdata/resp_hit hold until next response.
//  Reset mid-operation: next edge returns to reset values; outstanding mem transaction abandoned,
//   line contents invalidated (valid cleared), dirty data lost.
//  Request held on req_valid while req_ready=0 is not sampled; requester must hold it.
// CONFIGURATION
//  STATS_EN defined: hit_count/miss_count increment once per response (resp_hit selects), saturate
//   at 16'hFFFF, cleared by reset. Undefined: counter logic absent, both ports tied to 0.
// TESTING (INDEX_W=3, ADDR_W=16, DATA_W=16; mem model acks 2 cycles after mem_req)
//  1 reset, read 0x0005, mem returns 0x1234 -> one mem read @0x0005, resp 0x1234 hit=0; re-read ->
//    resp 1 cycle after accept, 0x1234, hit=1, no mem_req.
//  2 write 0x0005=0x00AB -> hit=1, no mem traffic; read 0x0005 -> 0x00AB hit=1.
//  3 read 0x000D (same index, dirty) -> mem write @0x0005 data 0x00AB, then mem read @0x000D
//    returning 0x5555 -> resp 0x5555 hit=0.
//  4 write 0x0020=0x0F0F (index 0 invalid) -> fill read @0x0020 only, resp hit=0; read 0x0020 -> 0x0F0F hit=1.
//  5 reset asserted during FILL wait -> next cycle mem_req=0, req_ready=1; read 0x0005 misses.
//  6 STATS_EN: 3 hits + 2 misses after reset -> hit_count=3, miss_count=2; without macro both 0.

Source files
------------

// File: rtl/cache_l1_wb.sv
// cache_l1_wb: direct-mapped, write-back, write-allocate L1 cache controller,
// one word per line, sitting between a CPU request port and the next memory level.
// Optional hit/miss statistics are enabled by defining the macro STATS_EN;
// without it o_hit_count/o_miss_count are tied to zero.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a request
// COMPARE    | tag lookup on the registered request; hits answer here
// WRITEBACK  | evicting a dirty victim line to the next level
// FILL       | fetching the requested word from the next level
// RESPOND    | applying the request to the filled line and answering
module cache_l1_wb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_hit,
    output logic              o_mem_req,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [15:0]       o_hit_count,
    output logic [15:0]       o_miss_count
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COMPARE   = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_hit;
    logic              r_mem_req;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_mem_done;

    assign w_idx      = r_addr[INDEX_W-1:0];
    assign w_tag      = r_addr[ADDR_W-1:INDEX_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // an ack only counts while a transaction is actually outstanding
    assign w_mem_done = i_mem_ack && r_mem_req;

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_hit   = r_resp_hit;
    assign o_mem_req    = r_mem_req;
    assign o_mem_write  = r_mem_write;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;

    // Controller FSM, request capture, line state bits and registered outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_hit   <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_write <= i_req_write;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_rdata <= r_write ? '0 : r_data[w_idx];
                        if (r_write) begin
                            r_dirty[w_idx] <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {r_tag[w_idx], w_idx};
                        r_mem_wdata <= r_data[w_idx];
                        r_state     <= S_WRITEBACK;
                    end else begin
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= r_addr;
                        r_state     <= S_FILL;
                    end
                end
                S_WRITEBACK: begin
                    // mem_req stays high straight into the fill
                    if (w_mem_done) begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= r_addr;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_mem_done) begin
                        r_mem_req      <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    r_resp_valid   <= 1'b1;
                    r_resp_hit     <= 1'b0;
                    r_resp_rdata   <= r_write ? '0 : r_data[w_idx];
                    r_dirty[w_idx] <= r_write;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays: no reset, validity is tracked by r_valid
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if ((r_state == S_COMPARE) && w_hit && r_write) begin
                r_data[w_idx] <= r_wdata;
            end
            if ((r_state == S_FILL) && w_mem_done) begin
                r_tag[w_idx]  <= w_tag;
                r_data[w_idx] <= i_mem_rdata;
            end
            if ((r_state == S_RESPOND) && r_write) begin
                r_data[w_idx] <= r_wdata;
            end
        end
    end

`ifdef STATS_EN
    logic        w_resp_fire;
    logic        w_resp_is_hit;
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    assign w_resp_fire   = ((r_state == S_COMPARE) && w_hit) || (r_state == S_RESPOND);
    assign w_resp_is_hit = (r_state == S_COMPARE);

    // Saturating hit/miss counters, one step per response
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_resp_fire) begin
            if (w_resp_is_hit) begin
                if (r_hit_count != 16'hFFFF) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end else begin
                if (r_miss_count != 16'hFFFF) begin
                    r_miss_count <= r_miss_count + 16'd1;
                end
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`else
    assign o_hit_count  = 16'd0;
    assign o_miss_count = 16'd0;
`endif

endmodule
